hps_fifo_responder: RTL and testbench

HPS_FIFO_RESPONDER -- requirements
Module: hps_fifo_responder

---
 rtl/hps_fifo_pkg.sv | 37 +++
 rtl/fifo_ram.sv | 48 ++++
 rtl/hps_fifo_responder.sv | 170 +++++++++++++++++
 tb/tb_hps_fifo_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hps_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hps_fifo_pkg
// Purpose : Shared constants and types for the HPS FIFO responder:
//           CSR address map, status / event bit indices, status word layout.
// Revision: 1.0 - initial release
// ============================================================================
package hps_fifo_pkg;

    // CSR address map
    localparam logic [2:0] c_ADDR_LEVEL  = 3'd0;
    localparam logic [2:0] c_ADDR_STATUS = 3'd1;
    localparam logic [2:0] c_ADDR_EVENT  = 3'd2;
    localparam logic [2:0] c_ADDR_AF     = 3'd4;
    localparam logic [2:0] c_ADDR_AE     = 3'd5;

    // Status register bit indices
    localparam int c_STAT_FULL   = 0;
    localparam int c_STAT_EMPTY  = 1;
    localparam int c_STAT_AFULL  = 2;
    localparam int c_STAT_AEMPTY = 3;

    // Sticky event register bit indices
    localparam int c_EVT_OVERFLOW  = 0;
    localparam int c_EVT_UNDERFLOW = 1;

    // Packed status word; first member is the MSB, so the layout matches
    // the bit indices above.
    typedef struct packed {
        logic almost_empty;
        logic almost_full;
        logic empty;
        logic full;
    } status_t;

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module  : fifo_ram
// Purpose : Simple dual-port DEPTH x DATA_W storage, synchronous write,
//           registered read (read-before-write on an address collision).
// Ports   : clk, rst        - clock, synchronous reset (read register only)
//           i_wr_en/addr/data - write port
//           i_rd_en/addr    - read port request
//           o_rd_data       - registered read data
// Revision: 1.0 - initial release
// ============================================================================
module fifo_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0]         i_wr_data,
    input  logic                      i_rd_en,
    input  logic [$clog2(DEPTH)-1:0]  i_rd_addr,
    output logic [DATA_W-1:0]         o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Non-blocking read alongside a same-address write returns the old word,
    // which is what a full-FIFO simultaneous push/pop relies on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/hps_fifo_responder.sv
`default_nettype none
// ============================================================================
// Module  : hps_fifo_responder
// Purpose : Avalon-style FIFO with push/pop streaming ports and a small CSR
//           block (level, status, AF/AE thresholds, optional sticky events).
// Ports   : clk, rst                       - clock, synchronous active-high reset
//           in_writedata/in_write/in_waitrequest   - producer (push) side
//           out_read/out_readdata/out_waitrequest  - consumer (pop) side
//           csr_address/read/write/writedata/readdata - CSR access port
// Config  : define HPS_FIFO_EVENT_EN to build the sticky event register
//           (CSR addr 2: bit0 overflow, bit1 underflow, write-1-to-clear).
// Revision: 1.0 - initial release
// ============================================================================
module hps_fifo_responder
    import hps_fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_writedata,
    input  logic              in_write,
    output logic              in_waitrequest,
    input  logic              out_read,
    output logic [DATA_W-1:0] out_readdata,
    output logic              out_waitrequest,
    input  logic [2:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_LVL_W  = c_ADDR_W + 1;

    logic [c_ADDR_W-1:0] r_head;
    logic [c_ADDR_W-1:0] r_tail;
    logic [c_LVL_W-1:0]  r_level;
    logic [31:0]         r_af_thr;
    logic [31:0]         r_ae_thr;
    logic [31:0]         r_csr_readdata;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_level_32;
    status_t     w_status;
    logic [31:0] w_csr_rdata;

    assign w_full     = (r_level == c_LVL_W'(DEPTH));
    assign w_empty    = (r_level == '0);
    assign w_level_32 = 32'(r_level);

    // A pop needs data; a push needs room, which a same-cycle pop provides.
    assign w_pop  = out_read && !w_empty;
    assign w_push = in_write && (!w_full || w_pop);

    assign in_waitrequest  = w_full;
    assign out_waitrequest = w_empty;

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push && !rst),
        .i_wr_addr (r_tail),
        .i_wr_data (in_writedata),
        .i_rd_en   (w_pop),
        .i_rd_addr (r_head),
        .o_rd_data (out_readdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Almost-empty excludes the empty state so that an idle FIFO reports
    // only the empty flag.
    always_comb begin
        w_status              = '0;
        w_status.full         = w_full;
        w_status.empty        = w_empty;
        w_status.almost_full  = (w_level_32 >= r_af_thr);
        w_status.almost_empty = !w_empty && (w_level_32 <= r_ae_thr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_af_thr <= 32'(DEPTH - 1);
            r_ae_thr <= 32'd1;
        end else if (csr_write) begin
            if (csr_address == c_ADDR_AF) begin
                r_af_thr <= csr_writedata;
            end
            if (csr_address == c_ADDR_AE) begin
                r_ae_thr <= csr_writedata;
            end
        end
    end

`ifdef HPS_FIFO_EVENT_EN
    logic [1:0] r_events;
    logic [1:0] w_evt_set;
    logic [1:0] w_evt_clr;

    always_comb begin
        w_evt_set                  = '0;
        w_evt_set[c_EVT_OVERFLOW]  = in_write && !w_push;
        w_evt_set[c_EVT_UNDERFLOW] = out_read && w_empty;
        w_evt_clr = (csr_write && csr_address == c_ADDR_EVENT) ?
                    csr_writedata[1:0] : 2'b00;
    end

    // Clear first, then OR in new events so a set in the same cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_events <= '0;
        end else begin
            r_events <= (r_events & ~w_evt_clr) | w_evt_set;
        end
    end
`endif

    always_comb begin
        w_csr_rdata = '0;
        case (csr_address)
            c_ADDR_LEVEL:  w_csr_rdata = w_level_32;
            c_ADDR_STATUS: w_csr_rdata = 32'(w_status);
`ifdef HPS_FIFO_EVENT_EN
            c_ADDR_EVENT:  w_csr_rdata = 32'(r_events);
`endif
            c_ADDR_AF:     w_csr_rdata = r_af_thr;
            c_ADDR_AE:     w_csr_rdata = r_ae_thr;
            default:       w_csr_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_csr_readdata <= '0;
        end else if (csr_read) begin
            r_csr_readdata <= w_csr_rdata;
        end
    end

    assign csr_readdata = r_csr_readdata;

endmodule
`default_nettype wire

// File: tb/tb_hps_fifo_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_hps_fifo_responder
// Purpose : Directed self-checking bench for hps_fifo_responder (DEPTH=256).
// Revision: 1.0 - initial release
// ============================================================================
module tb_hps_fifo_responder;

    logic        clk;
    logic        rst;
    logic [31:0] in_writedata;
    logic        in_write;
    logic        in_waitrequest;
    logic        out_read;
    logic [31:0] out_readdata;
    logic        out_waitrequest;
    logic [2:0]  csr_address;
    logic        csr_read;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;

    int n_checks;
    int n_fail;

    hps_fifo_responder #(
        .DATA_W (32),
        .DEPTH  (256)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_writedata    (in_writedata),
        .in_write        (in_write),
        .in_waitrequest  (in_waitrequest),
        .out_read        (out_read),
        .out_readdata    (out_readdata),
        .out_waitrequest (out_waitrequest),
        .csr_address     (csr_address),
        .csr_read        (csr_read),
        .csr_write       (csr_write),
        .csr_writedata   (csr_writedata),
        .csr_readdata    (csr_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock with the given stream inputs, then return to idle.
    task automatic step(input logic wr, input logic [31:0] wd, input logic rd);
        in_write     = wr;
        in_writedata = wd;
        out_read     = rd;
        @(posedge clk);
        #1;
        in_write = 1'b0;
        out_read = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] addr, output logic [31:0] data);
        csr_address = addr;
        csr_read    = 1'b1;
        @(posedge clk);
        #1;
        csr_read = 1'b0;
        data     = csr_readdata;
    endtask

    task automatic csr_wr(input logic [2:0] addr, input logic [31:0] data);
        csr_address   = addr;
        csr_writedata = data;
        csr_write     = 1'b1;
        @(posedge clk);
        #1;
        csr_write = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        in_write      = 1'b0;
        in_writedata  = '0;
        out_read      = 1'b0;
        csr_address   = '0;
        csr_read      = 1'b0;
        csr_write     = 1'b0;
        csr_writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_in_wait",  32'(in_waitrequest), 32'd0);
        check("rst_out_wait", 32'(out_waitrequest), 32'd1);
        check("rst_rdata",    out_readdata, 32'd0);
        check("rst_csr_rdata", csr_readdata, 32'd0);
        csr_rd(3'd1, rd); check("rst_status", rd, 32'h2);
        csr_rd(3'd0, rd); check("rst_level",  rd, 32'd0);
        csr_rd(3'd4, rd); check("rst_af",     rd, 32'd255);
        csr_rd(3'd5, rd); check("rst_ae",     rd, 32'd1);
        csr_rd(3'd3, rd); check("unmapped3",  rd, 32'd0);
        csr_wr(3'd6, 32'hFFFF_FFFF);
        csr_rd(3'd6, rd); check("unmapped6",  rd, 32'd0);

        // Basic ordering
        step(1'b1, 32'h11, 1'b0);
        step(1'b1, 32'h22, 1'b0);
        step(1'b1, 32'h33, 1'b0);
        csr_rd(3'd0, rd); check("lvl3",    rd, 32'd3);
        csr_rd(3'd1, rd); check("status3", rd, 32'h0);
        step(1'b0, 32'h0, 1'b1); check("pop_11", out_readdata, 32'h11);
        step(1'b0, 32'h0, 1'b1); check("pop_22", out_readdata, 32'h22);
        step(1'b0, 32'h0, 1'b1); check("pop_33", out_readdata, 32'h33);
        csr_rd(3'd0, rd); check("lvl_back0", rd, 32'd0);

        // Fill to capacity
        for (int i = 0; i < 256; i++) step(1'b1, 32'h100 + 32'(i), 1'b0);
        csr_rd(3'd1, rd); check("full_status", rd, 32'h5);
        check("full_in_wait", 32'(in_waitrequest), 32'd1);
        step(1'b1, 32'hDEAD, 1'b0);
        csr_rd(3'd0, rd); check("overflow_lvl", rd, 32'd256);
`ifdef HPS_FIFO_EVENT_EN
        csr_rd(3'd2, rd); check("evt_overflow", rd, 32'h1);
        csr_wr(3'd2, 32'h1);
        csr_rd(3'd2, rd); check("evt_ovf_clr", rd, 32'h0);
`else
        csr_rd(3'd2, rd); check("evt_absent", rd, 32'h0);
`endif

        // Simultaneous push/pop while full
        step(1'b1, 32'hAA, 1'b1);
        check("full_pp_rdata", out_readdata, 32'h100);
        csr_rd(3'd0, rd); check("full_pp_lvl", rd, 32'd256);
        for (int i = 0; i < 255; i++) begin
            step(1'b0, 32'h0, 1'b1);
            check("drain", out_readdata, 32'h101 + 32'(i));
        end
        step(1'b0, 32'h0, 1'b1);
        check("drain_last_AA", out_readdata, 32'hAA);
        check("drain_empty", 32'(out_waitrequest), 32'd1);

        // Empty with simultaneous push/pop: only the push lands
        step(1'b1, 32'h55, 1'b1);
        check("empty_pp_rdata", out_readdata, 32'hAA);
        csr_rd(3'd0, rd); check("empty_pp_lvl", rd, 32'd1);
        csr_rd(3'd1, rd); check("ae_status", rd, 32'h8);
        step(1'b0, 32'h0, 1'b1); check("pop_55", out_readdata, 32'h55);
        step(1'b0, 32'h0, 1'b1); check("underflow_hold", out_readdata, 32'h55);
        csr_rd(3'd0, rd); check("underflow_lvl", rd, 32'd0);
`ifdef HPS_FIFO_EVENT_EN
        csr_rd(3'd2, rd); check("evt_underflow", rd, 32'h2);
        // Clear underflow in the same cycle as a new underflow: set wins
        csr_address   = 3'd2;
        csr_writedata = 32'h2;
        csr_write     = 1'b1;
        step(1'b0, 32'h0, 1'b1);
        csr_write = 1'b0;
        csr_rd(3'd2, rd); check("evt_set_wins", rd, 32'h2);
        csr_wr(3'd2, 32'h3);
        csr_rd(3'd2, rd); check("evt_clr3", rd, 32'h0);
`else
        csr_wr(3'd2, 32'h3);
        csr_rd(3'd2, rd); check("evt_absent2", rd, 32'h0);
`endif

        // Read and write of the same register: read sees old value
        csr_address   = 3'd4;
        csr_writedata = 32'd10;
        csr_read      = 1'b1;
        csr_write     = 1'b1;
        @(posedge clk);
        #1;
        csr_read  = 1'b0;
        csr_write = 1'b0;
        check("rw_same_old", csr_readdata, 32'd255);
        csr_rd(3'd4, rd); check("af_written", rd, 32'd10);

        // Hold 10 words, then reset mid-operation
        for (int i = 0; i < 10; i++) step(1'b1, 32'h200 + 32'(i), 1'b0);
        csr_rd(3'd1, rd); check("af_at_10", rd, 32'h4);
        step(1'b0, 32'h0, 1'b1); check("pre_rst_pop", out_readdata, 32'h200);
        rst           = 1'b1;
        in_write      = 1'b1;
        in_writedata  = 32'hBAD;
        out_read      = 1'b1;
        csr_address   = 3'd5;
        csr_writedata = 32'd7;
        csr_write     = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_write  = 1'b0;
        out_read  = 1'b0;
        csr_write = 1'b0;
        check("mid_rst_rdata", out_readdata, 32'd0);
        check("mid_rst_empty", 32'(out_waitrequest), 32'd1);
        csr_rd(3'd0, rd); check("mid_rst_lvl",    rd, 32'd0);
        csr_rd(3'd1, rd); check("mid_rst_status", rd, 32'h2);
        csr_rd(3'd4, rd); check("mid_rst_af",     rd, 32'd255);
        csr_rd(3'd5, rd); check("mid_rst_ae",     rd, 32'd1);

        // Pointer wrap: 300 push/pop pairs
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 32'h1000 + 32'(i), 1'b0);
            step(1'b0, 32'h0, 1'b1);
            check("wrap", out_readdata, 32'h1000 + 32'(i));
        end
        csr_rd(3'd0, rd); check("wrap_lvl", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
